// File: rtl/pipe_pkg.sv
// Shared definitions for the skid pipeline stage: slot-state enum, default widths
// and the state-to-occupancy mapping.
package pipe_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   function automatic logic [1:0] occ_of(input state_t s);
      case (s)
         HALF:    occ_of = 2'd1;
         FULL:    occ_of = 2'd2;
         default: occ_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, falling-edge clocked, synchronous active-high clear.
// Holds at all-ones once reached; one-edge update latency.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(negedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage: one-edge latency, full throughput, in_ready registered (low only when FULL).
// Optional stall/flush performance counters exist only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
`ifdef PIPE_STAGE_PERF_EN
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
`endif
   output logic [1:0]        occupancy
);

   state_t            state, nxt_state;
   logic [DATA_W-1:0] main_data, skid_data;
   logic [DATA_W-1:0] nxt_main, nxt_skid;
   logic              accept, deliver;

   assign accept   = in_valid & in_ready;
   assign deliver  = out_valid & out_ready;
   assign out_data = main_data;

   // Vacated slots are cleared so an invalid slot always reads as zero.
   always_comb begin
      nxt_state = state;
      nxt_main  = main_data;
      nxt_skid  = skid_data;
      if (flush) begin
         nxt_state = EMPTY;
         nxt_main  = '0;
         nxt_skid  = '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  nxt_state = HALF;
                  nxt_main  = in_data;
               end
            end
            HALF: begin
               if (accept && deliver) begin
                  nxt_main = in_data;
               end else if (accept) begin
                  nxt_state = FULL;
                  nxt_skid  = in_data;
               end else if (deliver) begin
                  nxt_state = EMPTY;
                  nxt_main  = '0;
               end
            end
            FULL: begin
               if (deliver) begin
                  nxt_state = HALF;
                  nxt_main  = skid_data;
                  nxt_skid  = '0;
               end
            end
            default: begin
               nxt_state = EMPTY;
               nxt_main  = '0;
               nxt_skid  = '0;
            end
         endcase
      end
   end

   always_ff @(negedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         main_data <= '0;
         skid_data <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         occupancy <= 2'd0;
      end else begin
         state     <= nxt_state;
         main_data <= nxt_main;
         skid_data <= nxt_skid;
         out_valid <= (nxt_state != EMPTY);
         in_ready  <= (nxt_state != FULL);
         occupancy <= occ_of(nxt_state);
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (out_valid & ~out_ready),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush & (occupancy != 2'd0)),
      .count (flush_cnt)
   );
`else
   // CNT_W only sizes the counters; reference it so the plain build stays warning-free.
   logic unused_cnt_w;
   assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
